// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, memory,
// ALU, jump and branch steps and drives the datapath selects and strobes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read instruction at PC, PC+4 into PC when memory is ready
// DECODE | classify opcode, compute branch/JAL target into ALUOut
// MEMADR | compute load/store effective address
// MEMRD  | load access, waits for mem_ready
// MEMWB  | write load data into the register file
// MEMWR  | store access, waits for mem_ready
// EXEC_R | register-register ALU operation
// EXEC_I | register-immediate ALU operation
// ALUWB  | write ALUOut into the register file
// JAL    | load jump target (ALUOut) into PC
// JALR   | load rs1+imm into PC
// LINK   | write oldPC+4 into rd
// BRANCH | compare, conditionally load target into PC
// LUI    | pass the U immediate through the ALU
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_JAL    = 4'd9,
        S_JALR   = 4'd10,
        S_LINK   = 4'd11,
        S_BRANCH = 4'd12,
        S_LUI    = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t     state_q;
    state_t     state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};
    assign state             = state_q;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Immediate format follows the opcode regardless of the current state.
    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

    // Next-state and Moore outputs; strobes are squashed while in reset so a
    // pending memory access is abandoned without any write.
    always_comb begin
        state_d    = S_FETCH;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = instr[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_write = 1'b1;
                state_d  = S_LINK;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = S_LINK;
            end
            S_LINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                instr_done = 1'b1;
                // bne/blt/bltu take the branch when the compare is non-zero.
                case (funct3)
                    3'b001, 3'b100, 3'b110: pc_write = ~zero;
                    3'b010, 3'b011:         pc_write = 1'b0;
                    default:                pc_write = zero;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle output trace.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
    logic [2:0]  imm_src;
    logic        instr_done, illegal;
    logic [3:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                   ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC_R = 6, ST_EXEC_I = 7,
                   ST_ALUWB = 8, ST_JAL = 9, ST_JALR = 10, ST_LINK = 11,
                   ST_BRANCH = 12, ST_LUI = 13;

    localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_JAL = 4,
                   C_JALR = 5, C_BR = 6, C_LUI = 7, C_ILL = 8;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwe, adr, irw, pcw, rw;
        logic [1:0] a, b, rs;
        logic [2:0] imm;
        logic [1:0] op;
        logic       done, ill;
    } exp_t;

    exp_t exp_q[$];
    bit   mr_q[$];

    function automatic int class_of(input logic [6:0] opc);
        case (opc)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0110111: return C_LUI;
            default:    return C_ILL;
        endcase
    endfunction

    // Branch semantics: compare result zero means equal (beq) or
    // "not less than" (blt/bltu); 010/011 are never taken.
    function automatic logic taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000: return z;     // beq
            3'b001: return !z;    // bne
            3'b100: return !z;    // blt
            3'b101: return z;     // bge
            3'b110: return !z;    // bltu
            3'b111: return z;     // bgeu
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t exp_of(input int st, input logic [31:0] ins,
                                    input logic z, input bit mr);
        exp_t e;
        int   c;
        e = '0;
        c = class_of(ins[6:0]);
        e.st = st[3:0];
        case (c)
            C_STORE: e.imm = 3'd1;
            C_BR:    e.imm = 3'd2;
            C_JAL:   e.imm = 3'd3;
            C_LUI:   e.imm = 3'd4;
            default: e.imm = 3'd0;
        endcase
        case (st)
            ST_FETCH:  begin e.mreq = 1; e.b = 2; e.rs = 2; e.irw = mr; e.pcw = mr; end
            ST_DECODE: begin e.a = 1; e.b = 1; e.ill = (c == C_ILL); end
            ST_MEMADR: begin e.a = 2; e.b = 1; end
            ST_MEMRD:  begin e.mreq = 1; e.adr = 1; end
            ST_MEMWB:  begin e.rs = 1; e.rw = 1; e.done = 1; end
            ST_MEMWR:  begin e.mreq = 1; e.mwe = 1; e.adr = 1; e.done = mr; end
            ST_EXEC_R: begin e.a = 2; e.b = 0; e.op = 2; end
            ST_EXEC_I: begin e.a = 2; e.b = 1; e.op = 2; end
            ST_ALUWB:  begin e.rw = 1; e.done = 1; end
            ST_JAL:    begin e.pcw = 1; end
            ST_JALR:   begin e.a = 2; e.b = 1; e.rs = 2; e.pcw = 1; end
            ST_LINK:   begin e.a = 1; e.b = 2; e.rs = 2; e.rw = 1; e.done = 1; end
            ST_BRANCH: begin e.a = 2; e.op = 1; e.done = 1; e.pcw = taken(ins[14:12], z); end
            ST_LUI:    begin e.a = 3; e.b = 1; end
            default:   e = '0;
        endcase
        return e;
    endfunction

    function automatic void push(input int st, input logic [31:0] ins,
                                 input logic z, input bit mr);
        mr_q.push_back(mr);
        exp_q.push_back(exp_of(st, ins, z, mr));
    endfunction

    // Expected cycle trace of one instruction, starting in FETCH.
    // wf/wm = number of not-ready cycles for the fetch / data access.
    function automatic void build(input logic [31:0] ins, input logic z,
                                  input int wf, input int wm);
        exp_q.delete();
        mr_q.delete();
        for (int i = 0; i < wf; i++) push(ST_FETCH, ins, z, 1'b0);
        push(ST_FETCH, ins, z, 1'b1);
        push(ST_DECODE, ins, z, bit'($urandom_range(1)));
        case (class_of(ins[6:0]))
            C_LOAD: begin
                push(ST_MEMADR, ins, z, bit'($urandom_range(1)));
                for (int i = 0; i < wm; i++) push(ST_MEMRD, ins, z, 1'b0);
                push(ST_MEMRD, ins, z, 1'b1);
                push(ST_MEMWB, ins, z, bit'($urandom_range(1)));
            end
            C_STORE: begin
                push(ST_MEMADR, ins, z, bit'($urandom_range(1)));
                for (int i = 0; i < wm; i++) push(ST_MEMWR, ins, z, 1'b0);
                push(ST_MEMWR, ins, z, 1'b1);
            end
            C_R:   begin push(ST_EXEC_R, ins, z, 1'b1); push(ST_ALUWB, ins, z, 1'b0); end
            C_I:   begin push(ST_EXEC_I, ins, z, 1'b0); push(ST_ALUWB, ins, z, 1'b1); end
            C_LUI: begin push(ST_LUI, ins, z, 1'b1);    push(ST_ALUWB, ins, z, 1'b1); end
            C_JAL: begin push(ST_JAL, ins, z, 1'b1);    push(ST_LINK, ins, z, 1'b0); end
            C_JALR:begin push(ST_JALR, ins, z, 1'b0);   push(ST_LINK, ins, z, 1'b1); end
            C_BR:  push(ST_BRANCH, ins, z, bit'($urandom_range(1)));
            default: ;
        endcase
    endfunction

    // One clock: drive inputs on the falling edge, sample outputs 1 ns later.
    task automatic step(input bit mr, input logic [31:0] ins, input logic z,
                        output logic [22:0] act);
        @(negedge clk);
        mem_ready = mr;
        instr     = ins;
        zero      = z;
        #1;
        act = {state, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_op, instr_done, illegal};
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        instr     = 32'h0000_0013;
        zero      = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, illegal} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes actual=%b expected=0000000",
                     {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, illegal});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({state, mem_req, ir_write, pc_write} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state actual=%h/%b%b%b expected=0/000", state, mem_req, ir_write, pc_write);
        end
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({state, mem_req, adr_src, ir_write} !== {4'd0, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_release actual=%h/%b%b%b expected=0/100", state, mem_req, adr_src, ir_write);
        end
    endtask

    task automatic test_add;
        logic [22:0] act;
        logic [31:0] ins = 32'h0020_81B3;
        build(ins, 1'b0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            step(mr_q[i], ins, 1'b0, act);
            n_checks++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("FAIL add cyc%0d actual=%h expected=%h", i, act, exp_q[i]);
            end
        end
    endtask

    task automatic test_lw_wait;
        logic [22:0] act;
        logic [31:0] ins = 32'h0000_A283;
        build(ins, 1'b1, 0, 3);
        for (int i = 0; i < exp_q.size(); i++) begin
            step(mr_q[i], ins, 1'b1, act);
            n_checks++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lw_wait cyc%0d actual=%h expected=%h", i, act, exp_q[i]);
            end
        end
    endtask

    task automatic test_branches;
        logic [22:0] act;
        logic [31:0] br_ins [4] = '{32'h0000_0063, 32'h0000_1063, 32'h0000_4063, 32'h0000_7063};
        logic        br_z   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            build(br_ins[k], br_z[k], 1, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                step(mr_q[i], br_ins[k], br_z[k], act);
                n_checks++;
                if (act !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL branch%0d cyc%0d actual=%h expected=%h", k, i, act, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_jalr;
        logic [22:0] act;
        logic [31:0] ins = 32'h0002_80E7;
        build(ins, 1'b0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            step(mr_q[i], ins, 1'b0, act);
            n_checks++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("FAIL jalr cyc%0d actual=%h expected=%h", i, act, exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal;
        logic [22:0] act;
        logic [31:0] ins = 32'h0000_0000;
        build(ins, 1'b0, 0, 0);
        push(ST_FETCH, ins, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            step(mr_q[i], ins, 1'b0, act);
            n_checks++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("FAIL illegal cyc%0d actual=%h expected=%h", i, act, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_store;
        logic [22:0] act;
        logic [31:0] ins = 32'h0050_A023;
        build(ins, 1'b0, 0, 2);
        for (int i = 0; i < 4; i++) begin
            step(mr_q[i], ins, 1'b0, act);
            n_checks++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("FAIL store_pre cyc%0d actual=%h expected=%h", i, act, exp_q[i]);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if ({state, mem_req, mem_we, instr_done} !== {4'd5, 3'b000}) begin
            n_fail++;
            $display("FAIL store_abort actual=%h/%b%b%b expected=5/000", state, mem_req, mem_we, instr_done);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL store_abort_state actual=%h expected=0", state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random;
        logic [22:0] act;
        logic [31:0] ins;
        logic        z;
        logic [6:0]  ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};
        for (int n = 0; n < 150; n++) begin
            ins = $urandom;
            if ($urandom_range(9) != 0) ins[6:0] = ops[$urandom_range(7)];
            z = 1'(($urandom_range(1)));
            build(ins, z, int'($urandom_range(2)), int'($urandom_range(3)));
            for (int i = 0; i < exp_q.size(); i++) begin
                step(mr_q[i], ins, z, act);
                n_checks++;
                if (act !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random ins=%h cyc%0d actual=%h expected=%h", ins, i, act, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_branches();
        test_jalr();
        test_illegal();
        test_reset_mid_store();
        test_add();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 instr  in  32  current instruction-register contents.
REQ-005 zero  in  1  ALU zero flag; 1 = ALU result is 0.
REQ-006 mem_ready  in  1  memory handshake; 1 = access completes this cycle.
REQ-007 mem_req  out  1  memory access request.
REQ-008 mem_we  out  1  write qualifier for mem_req.
REQ-009 adr_src  out  1  0 = PC address, 1 = ALUOut address.
REQ-010 ir_write, pc_write, reg_write  out  1 each  register write strobes.
REQ-011 alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
REQ-012 alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-013 result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result.
REQ-014 imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-015 alu_op  out  2  00 add, 01 compare, 10 funct-decoded.
REQ-016 instr_done, illegal  out  1 each  one-cycle pulses.
REQ-017 state  out  4  current state, for debug.

Function
REQ-018 Moore FSM; outputs are a function of state, plus mem_ready and zero where stated; unlisted outputs = 0.
REQ-019 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALUWB 8, JAL 9, JALR 10, LINK 11, BRANCH 12, LUI 13; codes 14-15 go to FETCH.
REQ-020 FETCH: mem_req=1, adr_src=0, A=00, B=10, alu_op=00, result_src=10.
  - mem_ready=0: hold FETCH; ir_write=pc_write=0.
  - mem_ready=1: ir_write=pc_write=1; go to DECODE.
REQ-021 DECODE: A=01, B=01, alu_op=00 (branch/JAL target into ALUOut); next state by instr[6:0]:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R; 0010011 -> EXEC_I
  - 1101111 -> JAL; 1100111 -> JALR; 1100011 -> BRANCH; 0110111 -> LUI
  - any other opcode -> FETCH with illegal=1.
REQ-022 MEMADR: A=10, B=01, alu_op=00; next MEMRD if instr[5]=0, else MEMWR.
REQ-023 MEMRD: mem_req=1, adr_src=1; hold until mem_ready=1, then MEMWB.
REQ-024 MEMWB: result_src=01, reg_write=1, instr_done=1; next FETCH.
REQ-025 MEMWR: mem_req=mem_we=1, adr_src=1; hold until mem_ready=1, then FETCH with instr_done=1 in that completing cycle.
REQ-026 EXEC_R: A=10, B=00, alu_op=10. EXEC_I: A=10, B=01, alu_op=10. Both go to ALUWB.
REQ-027 LUI: A=11, B=01, alu_op=00; next ALUWB.
REQ-028 ALUWB: result_src=00, reg_write=1, instr_done=1; next FETCH.
REQ-029 JAL: result_src=00, pc_write=1; next LINK.
REQ-030 JALR: A=10, B=01, alu_op=00, result_src=10, pc_write=1; next LINK.
REQ-031 LINK: A=01, B=10, alu_op=00, result_src=10, reg_write=1, instr_done=1; next FETCH.
REQ-032 BRANCH: A=10, B=00, alu_op=01, result_src=00, instr_done=1; next FETCH.
  - pc_write = zero XOR (funct3 in {001,100,110}).
  - funct3 010/011: pc_write=0.
REQ-033 imm_src is decoded from instr[6:0] in every state:
  - I for load, OP-IMM and JALR; S for store; B for branch; J for JAL; U for LUI.
  - any other opcode -> 000.
REQ-034 mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Reset
REQ-035 On a rising edge with rst_n=0, state <= FETCH.
REQ-036 While rst_n=0, all of the following are forced to 0 combinationally: mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, illegal.
REQ-037 Reset during a pending access abandons the access with no strobe.
REQ-038 After reset, the first rst_n=1 cycle is FETCH with mem_req=1.

Verification
REQ-039 Reset, then add x3,x1,x2 with mem_ready=1 -> states 0,1,6,8,0; reg_write only in ALUWB; instr_done once.
REQ-040 lw, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req=1, adr_src=1, then MEMWB with result_src=01, reg_write=1.
REQ-041 beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; blt zero=0 -> pc_write=1; bgeu zero=0 -> pc_write=0.
REQ-042 jalr x1,0(x5) -> JALR (pc_write=1, A=10, B=01), then LINK (reg_write=1, A=01, B=10), then FETCH.
REQ-043 opcode 0000000 -> illegal=1 in DECODE, next FETCH, no write strobes.
REQ-044 rst_n=0 mid-MEMWR with mem_ready=0 -> mem_we=0 immediately; state=FETCH after the edge.
